// File: rtl/regfile_read_port_pkg.sv
// -----------------------------------------------------------------------------
// regfile_read_port_pkg
// Shared constants for the MIPS general-purpose register file. Decode and
// write-back import the same definitions, so register widths and the
// hardwired-zero index are defined once here.
//   DATA_W   : register width in bits
//   ADDR_W   : register index width
//   NREGS    : number of architectural registers (2**ADDR_W)
//   ZERO_REG : index of $zero, which always reads 0 and never becomes busy
// -----------------------------------------------------------------------------
package regfile_read_port_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // True for the hardwired $zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (addr == ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register, marking a destination whose
// producer has been issued but has not yet written back. Also decides whether
// each read source is usable this cycle.
//   clk, rst            : clock, synchronous active-low reset
//   flush               : clear every busy bit
//   set_en, set_addr    : reserve a destination (from an accepted request)
//   clr_en, clr_addr    : write-back strobe and destination
//   rs_addr, rt_addr    : the two read sources under test
//   rs_ok, rt_ok        : source is not busy, or is being written back now
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_read_port_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_ok,
  output logic              rt_ok
);

  logic [NREGS-1:0] r_busy;
  logic             w_clr_hit;

  // A write-back to $zero carries no real producer, so it clears nothing
  // and bypasses nothing.
  assign w_clr_hit = clr_en && !is_zero_reg(clr_addr);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (w_clr_hit) begin
        r_busy[clr_addr] <= 1'b0;
      end
      // Placed after the clear so that a same-edge reservation of the
      // written register wins: the new producer is still outstanding.
      if (set_en && !is_zero_reg(set_addr)) begin
        r_busy[set_addr] <= 1'b1;
      end
    end
  end

  // busy[0] is never set, so $zero is always ready.
  assign rs_ok = !r_busy[rs_addr] || (w_clr_hit && (clr_addr == rs_addr));
  assign rt_ok = !r_busy[rt_addr] || (w_clr_hit && (clr_addr == rt_addr));

endmodule

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// Read side of the MIPS register file between decode and execute. Holds the
// 32 x 32-bit array, accepts two-source read requests, takes write-back data
// (bypassed to same-cycle readers) and stalls requests whose sources are
// still reserved by an in-flight producer.
//   clk, rst            : clock, synchronous active-low reset
//   req_valid/req_ready : read request handshake (ready is combinational)
//   rs_addr, rt_addr    : source registers
//   rd_reserve, rd_addr : mark rd_addr busy when the request is accepted
//   rsp_valid           : one-cycle pulse, rs_data/rt_data valid
//   rs_data, rt_data    : registered source values
//   wb_en/addr/data     : write-back port
//   flush               : drop all reservations and the pending response
// -----------------------------------------------------------------------------
module regfile_read_port
  import regfile_read_port_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rd_reserve,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;

  logic              w_wb_hit;
  logic              w_rs_ok;
  logic              w_rt_ok;
  logic              w_accept;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;

  assign w_wb_hit  = wb_en && !is_zero_reg(wb_addr);
  assign req_ready = w_rs_ok && w_rt_ok && !flush;
  assign w_accept  = req_valid && req_ready;

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (w_accept && rd_reserve),
    .set_addr (rd_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_ok    (w_rs_ok),
    .rt_ok    (w_rt_ok)
  );

  // NOTE: the array is cleared on reset because software may read any
  // register before writing it and must see 0; this keeps it in flops
  // rather than a RAM macro, which is acceptable at 32 entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_hit) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Source operand selection: $zero, then same-cycle write-back, then array.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rs_val = r_regs[rs_addr];
    if (is_zero_reg(rs_addr)) begin
      w_rs_val = '0;
    end else if (w_wb_hit && (wb_addr == rs_addr)) begin
      w_rs_val = wb_data;
    end
  end

  always_comb begin
    w_rt_val = r_regs[rt_addr];
    if (is_zero_reg(rt_addr)) begin
      w_rt_val = '0;
    end else if (w_wb_hit && (wb_addr == rt_addr)) begin
      w_rt_val = wb_data;
    end
  end

  // Response registers. Flush needs no term here: it forces req_ready low,
  // so no accept happens and rsp_valid falls on its own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rs_data <= w_rs_val;
        r_rt_data <= w_rt_val;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rs_data   = r_rs_data;
  assign rt_data   = r_rt_data;

endmodule

// File: tb/tb_regfile_read_port.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_port
// Directed scenarios for the register-file read port. Inputs change 1 ns
// after the rising edge; req_ready is sampled 1 ns later within the same
// cycle, registered outputs 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_read_port;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rd_reserve;
  logic [4:0]  rd_addr;
  logic        rsp_valid;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;

  int checks = 0;
  int errors = 0;

  regfile_read_port dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_reserve (rd_reserve),
    .rd_addr    (rd_addr),
    .rsp_valid  (rsp_valid),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic res, input logic [4:0] rd,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl);
    req_valid  = v;
    rs_addr    = rs;
    rt_addr    = rt;
    rd_reserve = res;
    rd_addr    = rd;
    wb_en      = we;
    wb_addr    = wa;
    wb_data    = wd;
    flush      = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 3, 0, 1, 3, 1, 3, 32'h1234, 0);
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs_data got %h exp 0", rs_data); end
    checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt_data got %h exp 0", rt_data); end
    rst = 1'b1;
    drive(1, 3, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL reset_read_valid got %0b exp 1", rsp_valid); end
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_read_rs got %h exp 0", rs_data); end
    checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL reset_read_rt got %h exp 0", rt_data); end
    idle();
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_write_read();
    drive(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    tick();
    drive(1, 5, 5, 0, 0, 0, 0, 32'h0, 0);
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_valid got %0b exp 1", rsp_valid); end
    checks++; if (rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rs got %h exp deadbeef", rs_data); end
    checks++; if (rt_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rt got %h exp deadbeef", rt_data); end
    drive(0, 0, 0, 0, 0, 1, 0, 32'h0000BABE, 0);
    tick();
    checks++; if (rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rs got %h exp deadbeef", rs_data); end
    drive(1, 0, 5, 0, 0, 0, 0, 32'h0, 0);
    tick();
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL zero_read got %h exp 0", rs_data); end
    checks++; if (rt_data !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_read_rt got %h exp deadbeef", rt_data); end
  endtask

  task automatic test_bypass();
    drive(0, 0, 0, 0, 0, 1, 7, 32'h1, 0);
    tick();
    drive(1, 7, 5, 0, 0, 1, 7, 32'h1111BABE, 0);
    tick();
    checks++; if (rs_data !== 32'h1111BABE) begin errors++; $display("FAIL bypass_rs got %h exp 1111babe", rs_data); end
    checks++; if (rt_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rt got %h exp deadbeef", rt_data); end
    drive(1, 5, 7, 0, 0, 0, 0, 32'h0, 0);
    tick();
    checks++; if (rt_data !== 32'h1111BABE) begin errors++; $display("FAIL bypass_stored got %h exp 1111babe", rt_data); end
  endtask

  task automatic test_stall();
    drive(1, 5, 0, 1, 9, 0, 0, 32'h0, 0);
    tick();
    drive(1, 9, 0, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0b exp 0", i, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %0b exp 0", i, rsp_valid); end
    end
    drive(1, 9, 0, 0, 0, 1, 9, 32'h0000CAFE, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wb_release_ready got %0b exp 1", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wb_release_valid got %0b exp 1", rsp_valid); end
    checks++; if (rs_data !== 32'h0000CAFE) begin errors++; $display("FAIL wb_release_rs got %h exp 0000cafe", rs_data); end
    drive(1, 0, 9, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL busy9_cleared got %0b exp 1", req_ready); end
    tick();
    checks++; if (rt_data !== 32'h0000CAFE) begin errors++; $display("FAIL after_wb_rt got %h exp 0000cafe", rt_data); end
    // Reserving $zero must be ignored.
    drive(1, 0, 0, 1, 0, 0, 0, 32'h0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_reserve got %0b exp 1", req_ready); end
    tick();
    // Read-and-reserve the same register, then stall on the rt path.
    drive(1, 9, 0, 1, 9, 0, 0, 32'h0, 0);
    tick();
    checks++; if (rs_data !== 32'h0000CAFE) begin errors++; $display("FAIL self_reserve_rs got %h exp 0000cafe", rs_data); end
    drive(1, 0, 9, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rt_stall got %0b exp 1'b0", req_ready); end
    drive(0, 0, 0, 0, 0, 1, 9, 32'h99, 0);
    tick();
    drive(1, 0, 9, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rt_release got %0b exp 1", req_ready); end
    tick();
    checks++; if (rt_data !== 32'h99) begin errors++; $display("FAIL rt_release_data got %h exp 99", rt_data); end
  endtask

  task automatic test_set_wins();
    drive(1, 0, 0, 1, 4, 0, 0, 32'h0, 0);
    tick();
    drive(1, 4, 0, 1, 4, 1, 4, 32'h44, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL setwins_ready got %0b exp 1", req_ready); end
    tick();
    checks++; if (rs_data !== 32'h44) begin errors++; $display("FAIL setwins_rs got %h exp 44", rs_data); end
    drive(1, 4, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL setwins_busy got %0b exp 0", req_ready); end
    drive(1, 4, 0, 0, 0, 0, 0, 32'h0, 1);
    tick();
    drive(1, 4, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL setwins_flushed got %0b exp 1", req_ready); end
    tick();
    checks++; if (rs_data !== 32'h44) begin errors++; $display("FAIL setwins_reg got %h exp 44", rs_data); end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 1, 2, 0, 0, 32'h0, 0);
    tick();
    drive(1, 0, 0, 1, 6, 0, 0, 32'h0, 0);
    tick();
    drive(1, 2, 6, 0, 0, 1, 2, 32'h22, 1);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", rsp_valid); end
    drive(1, 2, 6, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready got %0b exp 1", req_ready); end
    tick();
    checks++; if (rs_data !== 32'h22) begin errors++; $display("FAIL flush_wb_rs got %h exp 22", rs_data); end
    checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL flush_rt got %h exp 0", rt_data); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rs_v [4] = '{5'd1, 5'd7, 5'd9, 5'd0};
    logic [4:0]  rt_v [4] = '{5'd5, 5'd1, 5'd4, 5'd2};
    logic [31:0] ers  [4] = '{32'h101, 32'h1111BABE, 32'h99, 32'h0};
    logic [31:0] ert  [4] = '{32'hDEADBEEF, 32'h101, 32'h44, 32'h22};
    drive(0, 0, 0, 0, 0, 1, 1, 32'h101, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, rs_v[i], rt_v[i], 0, 0, 0, 0, 32'h0, 0);
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0b exp 1", i, rsp_valid); end
      checks++; if (rs_data !== ers[i]) begin errors++; $display("FAIL b2b_rs[%0d] got %h exp %h", i, rs_data, ers[i]); end
      checks++; if (rt_data !== ert[i]) begin errors++; $display("FAIL b2b_rt[%0d] got %h exp %h", i, rt_data, ert[i]); end
    end
  endtask

  task automatic test_mid_reset();
    drive(1, 5, 7, 1, 12, 0, 0, 32'h0, 0);
    tick();
    checks++; if (rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_rs got %h exp deadbeef", rs_data); end
    rst = 1'b0;
    drive(1, 5, 7, 0, 0, 1, 5, 32'h55, 0);
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", rsp_valid); end
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL midrst_rs got %h exp 0", rs_data); end
    checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL midrst_rt got %h exp 0", rt_data); end
    rst = 1'b1;
    drive(1, 12, 5, 0, 0, 0, 0, 32'h0, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_busy got %0b exp 1", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_read_valid got %0b exp 1", rsp_valid); end
    checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL midrst_regs got %h exp 0", rt_data); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_stall();
    test_set_wins();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
